// File: rtl/sd_pkg.sv
// Shared constants, FSM state codes and request struct for the SPI-mode SD command transactor.
package sd_pkg;

  localparam int         CMD_FRAME_W = 48;
  localparam int         RSP_W       = 40;
  localparam logic [6:0] CRC7_POLY   = 7'h09;

  localparam logic [1:0] RSP_R1  = 2'd0;
  localparam logic [1:0] RSP_R1B = 2'd1;
  localparam logic [1:0] RSP_R37 = 2'd2;

  typedef logic [2:0] sd_state_t;
  localparam sd_state_t ST_IDLE  = 3'd0;
  localparam sd_state_t ST_PRE   = 3'd1;
  localparam sd_state_t ST_CMD   = 3'd2;
  localparam sd_state_t ST_WAIT  = 3'd3;
  localparam sd_state_t ST_RECV  = 3'd4;
  localparam sd_state_t ST_BUSYW = 3'd5;
  localparam sd_state_t ST_DONE  = 3'd6;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] argument;
    logic [1:0]  rsp_type;
  } cmd_req_t;

  function automatic int umax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one bit per clock, MSB-first input.
import sd_pkg::*;

module sd_crc7 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clk) begin
    if (reset || clr) crc <= '0;
    else if (en)      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/sd_cmd_txn.sv
// SPI-mode SD command transactor: frames CMD, hunts/captures R1/R1b/R3/R7, with timeouts.
// Define SD_CMD_RETRY_EN to re-issue the command up to RETRIES times after a timeout.
import sd_pkg::*;

module sd_cmd_txn #(
  parameter int PRE_CLKS     = 8,
  parameter int RSP_TIMEOUT  = 100,
  parameter int BUSY_TIMEOUT = 65535,
  parameter int RETRIES      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  index,
  input  logic [31:0] argument,
  input  logic [1:0]  rsp_type,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [39:0] response,
  output logic        DI,
  input  logic        DO
);

  localparam int CNT_MAX = umax(umax(PRE_CLKS, CMD_FRAME_W), umax(RSP_TIMEOUT + 1, BUSY_TIMEOUT));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (PRE_CLKS < 1 || RETRIES < 0) begin : g_bad_cfg
    $error("sd_cmd_txn: PRE_CLKS must be >= 1 and RETRIES >= 0");
  end

  sd_state_t          state;
  cmd_req_t           req;
  logic [CNT_W-1:0]   cnt;
  logic [RSP_W-1:0]   shreg;
  logic [6:0]         crc;
  logic [39:0]        hdr;
  logic [5:0]         bidx;
  logic               fbit;
  logic               rsp_to;
  logic               busy_to;
  logic [CNT_W-1:0]   rsp_len;

`ifdef SD_CMD_RETRY_EN
  localparam int ATT_W = $clog2(RETRIES + 2);
  logic [ATT_W-1:0] attempt;
`endif

  assign hdr     = {2'b01, req.index, req.argument};
  assign bidx    = cnt[5:0];
  assign rsp_len = (req.rsp_type == RSP_R37) ? CNT_W'(RSP_W) : CNT_W'(8);
  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);

  // Frame bit for the current CMD cycle: 40 header bits, 7 CRC bits, end bit.
  always_comb begin
    fbit = 1'b1;
    if (bidx < 6'd40)      fbit = hdr[6'd39 - bidx];
    else if (bidx < 6'd47) fbit = crc[3'(6'd46 - bidx)];
  end

  always_comb begin
    rsp_to  = (state == ST_WAIT)  &&  DO && (cnt == CNT_W'(RSP_TIMEOUT));
    busy_to = (state == ST_BUSYW) && !DO && (cnt == CNT_W'(BUSY_TIMEOUT - 1));
  end

  sd_crc7 u_crc7 (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == ST_PRE),
    .en     ((state == ST_CMD) && (bidx < 6'd40)),
    .bit_in (fbit),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      req      <= '0;
      cnt      <= '0;
      shreg    <= '1;
      response <= '1;
      timeout  <= 1'b0;
      DI       <= 1'b1;
`ifdef SD_CMD_RETRY_EN
      attempt  <= '0;
`endif
    end else begin
      DI <= 1'b1;
      case (state)
        ST_IDLE: if (start) begin
          req.index    <= index;
          req.argument <= argument;
          req.rsp_type <= (rsp_type == 2'd3) ? RSP_R1 : rsp_type;
          response     <= '1;
          timeout      <= 1'b0;
          cnt          <= '0;
`ifdef SD_CMD_RETRY_EN
          attempt      <= '0;
`endif
          state        <= ST_PRE;
        end
        ST_PRE: begin
          if (cnt == CNT_W'(PRE_CLKS - 1)) begin
            cnt   <= '0;
            state <= ST_CMD;
          end else cnt <= cnt + 1'b1;
        end
        // DI is registered, so each bit reaches the card one cycle after its CMD slot.
        ST_CMD: begin
          DI <= fbit;
          if (cnt == CNT_W'(CMD_FRAME_W - 1)) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end else cnt <= cnt + 1'b1;
        end
        ST_WAIT: begin
          if (!DO) begin
            shreg <= {shreg[RSP_W-2:0], DO};
            cnt   <= CNT_W'(1);
            state <= ST_RECV;
          end else cnt <= cnt + 1'b1;
        end
        ST_RECV: begin
          if (cnt == rsp_len) begin
            response <= (req.rsp_type == RSP_R37) ? shreg : {32'hFFFF_FFFF, shreg[7:0]};
            cnt      <= '0;
            state    <= (req.rsp_type == RSP_R1B) ? ST_BUSYW : ST_DONE;
          end else begin
            shreg <= {shreg[RSP_W-2:0], DO};
            cnt   <= cnt + 1'b1;
          end
        end
        ST_BUSYW: begin
          if (DO) state <= ST_DONE;
          else    cnt   <= cnt + 1'b1;
        end
        ST_DONE: if (!start) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Timeouts override whatever the WAIT/BUSYW branch chose above.
      if (rsp_to || busy_to) begin
`ifdef SD_CMD_RETRY_EN
        if (attempt < ATT_W'(RETRIES)) begin
          attempt <= attempt + 1'b1;
          cnt     <= '0;
          state   <= ST_PRE;
        end else
`endif
        begin
          timeout <= 1'b1;
          if (rsp_to) response <= '1;
          cnt     <= '0;
          state   <= ST_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_txn.sv
// Randomized self-checking bench for sd_cmd_txn with a behavioural card/frame model.
module tb_sd_cmd_txn;

  localparam int PRE = 8;
  localparam int RTO = 100;
  localparam int BTO = 65535;
  localparam int RTR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  index = '0;
  logic [31:0] argument = '0;
  logic [1:0]  rsp_type = '0;
  logic        DO = 1'b1;
  logic        busy, done, timeout, DI;
  logic [39:0] response;

  sd_cmd_txn #(.PRE_CLKS(PRE), .RSP_TIMEOUT(RTO), .BUSY_TIMEOUT(BTO), .RETRIES(RTR)) dut (
    .clk(clk), .reset(reset), .start(start), .index(index), .argument(argument),
    .rsp_type(rsp_type), .busy(busy), .done(done), .timeout(timeout),
    .response(response), .DI(DI), .DO(DO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: a 0 on an idle-high DI starts a 48-bit frame.
  int          nframes = 0;
  int          fbits = 0;
  int          fstart_cyc = 0;
  logic [47:0] cur, last_frame;
  always @(negedge clk) begin
    if (reset) fbits = 0;
    else if (fbits > 0 || DI == 1'b0) begin
      if (fbits == 0) fstart_cyc = cyc;
      cur = {cur[46:0], DI};
      fbits++;
      if (fbits == 48) begin
        last_frame = cur;
        nframes++;
        fbits = 0;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    logic [6:0]  c;
    logic        fb;
    h = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = h[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return {h, c, 1'b1};
  endfunction

  // One full transaction; card answers d cycles after the end bit, R1b holds DO=0 for blen cycles.
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input int d, input logic [39:0] rv, input int blen);
    int n, base, t0, w, lat;
    logic [39:0] exp_rsp;
    n       = (rt == 2'd2) ? 40 : 8;
    exp_rsp = (n == 40) ? rv : {32'hFFFF_FFFF, rv[7:0]};
    lat     = PRE + 49 + d + n + ((rt == 2'd1) ? blen : 0);
    base    = nframes;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    index = idx; argument = arg; rsp_type = rt; start = 1'b1;
    step();
    t0 = cyc;
    chk("busy_on", busy, 1);
    chk("rsp_cleared", response, 40'hFF_FFFF_FFFF);
    w = 0;
    while (nframes == base && w < 300) begin step(); w++; end
    chk("frame_seen", nframes, base + 1);
    chk("frame", last_frame, frame_of(idx, arg));
    chk("first_bit", fstart_cyc - t0, PRE + 1);
    repeat (d - 1) step();
    for (int i = n - 1; i >= 0; i--) begin DO = rv[i]; step(); end
    if (rt == 2'd1) begin
      DO = 1'b0;
      repeat (blen) step();
    end
    DO = 1'b1;
    chk("done_early", done, 0);
    step();
    chk("done_rise", done, 1);
    chk("latency", cyc - t0, lat);
    chk("response", response, exp_rsp);
    chk("timeout0", timeout, 0);
    chk("busy_off", busy, 0);
    repeat (4) step();
    chk("done_hold", done, 1);
    chk("no_retrigger", nframes, base + 1);
    chk("rsp_stable", response, exp_rsp);
    start = 1'b0;
    step();
    chk("done_clr", done, 0);
  endtask

  initial begin
    int base, w, exp_frames, rt_i, d, blen;
    logic [1:0]  rt;
    logic [39:0] rv;
    logic [31:0] ra, rb;
    logic [5:0]  ri;

    repeat (3) step();
    chk("rst_DI", DI, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_response", response, 40'hFF_FFFF_FFFF);
    reset = 1'b0;
    step();

    run_txn(6'd0, 32'h0, 2'd0, 3, 40'h01, 0);
    chk("cmd0_frame", last_frame, 48'h40_0000_0000_95);
    run_txn(6'd8, 32'h1AA, 2'd2, 2, 40'h01_0000_01AA, 0);
    chk("cmd8_crc", last_frame[7:0], 8'h87);
    run_txn(6'd12, 32'h0, 2'd1, 1, 40'h00, 20);

    for (int k = 0; k < 8; k++) begin
      rt_i = $urandom_range(0, 3);
      rt   = 2'(rt_i);
      ra   = $urandom;
      rb   = $urandom;
      ri   = 6'(rb);
      rv   = {rb[15:8], ra};
      if (rt == 2'd2) rv[39] = 1'b0;
      else            rv[7]  = 1'b0;
      d    = $urandom_range(1, 12);
      blen = $urandom_range(1, 30);
      run_txn(ri, $urandom, rt, d, rv, blen);
    end

    // Card never answers.
    base = nframes;
    index = 6'd17; argument = 32'h1234_5678; rsp_type = 2'd0; start = 1'b1;
    DO = 1'b1;
    step();
    w = 0;
    while (!done && w < 3000) begin step(); w++; end
`ifdef SD_CMD_RETRY_EN
    exp_frames = 1 + RTR;
`else
    exp_frames = 1;
`endif
    chk("to_done", done, 1);
    chk("to_flag", timeout, 1);
    chk("to_response", response, 40'hFF_FFFF_FFFF);
    chk("to_frames", nframes - base, exp_frames);
    start = 1'b0;
    step();

    // Reset in the middle of a frame.
    index = 6'd17; argument = 32'hDEAD_BEEF; rsp_type = 2'd0; start = 1'b1;
    step();
    w = 0;
    while (fbits < 21 && w < 100) begin step(); w++; end
    chk("mid_frame_reached", fbits >= 21, 1);
    reset = 1'b1;
    step();
    chk("midrst_DI", DI, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_response", response, 40'hFF_FFFF_FFFF);
    reset = 1'b0; start = 1'b0;
    step();
    run_txn(6'd17, 32'h0000_0200, 2'd0, 4, 40'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
